spi_word_receiver: RTL and testbench

Mode-0 SPI receiver that accepts 32-bit MSB-first frames from the team's SPI word transmitter (sclk idle low, mosi launched on falling sclk, sampled here on rising sclk, cs active low). It oversamples sclk, cs and mosi in the system clock domain and presents each completed word on a valid/ready output port. Malformed frames are flagged, and so are words arriving while the previous word is still unaccepted. It sits at the far end of the SPI link, feeding the consumer logic.

---
 rtl/spi_word_receiver.sv | 165 ++++++++++++++++
 tb/tb_spi_word_receiver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_receiver.sv
// Mode-0 SPI word receiver: oversamples sclk/cs/mosi in the clk domain and delivers
// MSB-first DATA_W-bit frames on a valid/ready port, flagging malformed frames and overruns.
module spi_word_receiver #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              sclk_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              overrun_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        RECV,
        DONE
    } state_t;

    localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sclkSync_q;
    logic [SYNC_STAGES-1:0] csSync_q;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic [SYNC_STAGES-1:0] primed_q;
    logic                   sclkPrev_q;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [5:0]             bitCnt_q, bitCnt_d;
    logic                   excess_q, excess_d;
    logic [DATA_W-1:0]      dout_q, dout_d;
    logic                   doutValid_q, doutValid_d;
    logic                   overrun_q, overrun_d;
    logic                   frameErr_q, frameErr_d;
    logic                   busy_q, busy_d;

    logic                   sclkS, csS, mosiS, primed;
    logic                   sclkRise, lastRise, deliver;
    logic [DATA_W-1:0]      word;

    assign sclkS    = sclkSync_q[SYNC_STAGES-1];
    assign csS      = csSync_q[SYNC_STAGES-1];
    assign mosiS    = mosiSync_q[SYNC_STAGES-1];
    assign primed   = primed_q[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkPrev_q;
    assign lastRise = sclkRise && (bitCnt_q == LAST_BIT);
    assign word     = {shift_q[DATA_W-2:0], mosiS};

    // primed_q tracks when the synchronizers hold real pin samples rather than reset
    // values, so ARM cannot mistake the reset value of cs_s for a genuine idle bus.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sclkSync_q <= '0;
            csSync_q   <= '1;
            mosiSync_q <= '0;
            primed_q   <= '0;
            sclkPrev_q <= 1'b0;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk_i};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs_i};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi_i};
            primed_q   <= {primed_q[SYNC_STAGES-2:0], 1'b1};
            sclkPrev_q <= sclkS;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ARM;
            shift_q     <= '0;
            bitCnt_q    <= '0;
            excess_q    <= 1'b0;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frameErr_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            excess_q    <= excess_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
            overrun_q   <= overrun_d;
            frameErr_q  <= frameErr_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM:     if (primed && csS) state_d = IDLE;
            IDLE:    if (!csS) state_d = RECV;
            RECV: begin
                if (csS)           state_d = IDLE;
                else if (lastRise) state_d = DONE;
            end
            DONE:    if (csS) state_d = IDLE;
            default: state_d = ARM;
        endcase
    end

    always_comb begin
        shift_d    = shift_q;
        bitCnt_d   = bitCnt_q;
        excess_d   = excess_q;
        frameErr_d = 1'b0;
        deliver    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!csS) begin
                    bitCnt_d = '0;
                    excess_d = 1'b0;
                end
            end
            RECV: begin
                if (csS) begin
                    frameErr_d = 1'b1;
                end else if (sclkRise) begin
                    shift_d = word;
                    if (bitCnt_q != '1) bitCnt_d = bitCnt_q + 6'd1;
                    deliver = lastRise;
                end
            end
            DONE: begin
                if (csS)           frameErr_d = excess_q;
                else if (sclkRise) excess_d   = 1'b1;
            end
            default: ;
        endcase

        // A delivery while the held word is still unaccepted drops the new word;
        // acceptance and delivery in the same cycle simply replace the word.
        dout_d      = dout_q;
        doutValid_d = doutValid_q;
        overrun_d   = 1'b0;
        if (doutValid_q && dout_ready_i) doutValid_d = 1'b0;
        if (deliver) begin
            if (doutValid_q && !dout_ready_i) begin
                overrun_d = 1'b1;
            end else begin
                dout_d      = word;
                doutValid_d = 1'b1;
            end
        end
        busy_d = (state_d != IDLE);
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = doutValid_q;
    assign overrun_o    = overrun_q;
    assign frame_err_o  = frameErr_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_spi_word_receiver.sv
// Scoreboard bench for spi_word_receiver: a frame-level model predicts delivered words,
// overruns and frame errors; a monitor compares whenever the DUT hands over a word.
module tb_spi_word_receiver;

    logic        clk = 1'b0;
    logic        rstN;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic        doutReady;
    logic [31:0] dout;
    logic        doutValid;
    logic        overrun;
    logic        frameErr;
    logic        busy;

    int          compared    = 0;
    int          mismatched  = 0;
    int          expFrameErr = 0;
    int          expOverrun  = 0;
    int          obsFrameErr = 0;
    int          obsOverrun  = 0;
    bit          held        = 1'b0;
    logic [31:0] expQ[$];

    spi_word_receiver #(.DATA_W(32), .SYNC_STAGES(2)) dut (
        .clk_i        (clk),
        .rst_n_i      (rstN),
        .sclk_i       (sclk),
        .cs_i         (cs),
        .mosi_i       (mosi),
        .dout_o       (dout),
        .dout_valid_o (doutValid),
        .dout_ready_i (doutReady),
        .overrun_o    (overrun),
        .frame_err_o  (frameErr),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: a word is handed over in any cycle where valid and ready are both high.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rstN) begin
                if (frameErr) obsFrameErr++;
                if (overrun)  obsOverrun++;
                if (doutValid && doutReady) begin
                    if (expQ.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected word: got 0x%08h expected none", dout);
                    end else begin
                        checkOutput("word", dout, expQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setReady(input logic v);
        doutReady = v;
        if (v) held = 1'b0;
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, " frame_err count"}, 32'(obsFrameErr), 32'(expFrameErr));
        checkOutput({tag, " overrun count"}, 32'(obsOverrun), 32'(expOverrun));
        checkOutput({tag, " pending words"}, 32'(expQ.size()), 32'd0);
    endtask

    // Sends one frame of nbits; the first 32 bits come from word MSB-first, any extra
    // bits are random. resetAt >= 0 pulses reset after that bit index.
    task automatic applyStimulus(input logic [31:0] word, input int nbits, input int resetAt, input bit checkLat);
        if (resetAt >= 0) begin
            held = 1'b0;
        end else begin
            if (nbits != 32) expFrameErr++;
            if (nbits >= 32) begin
                if (held && !doutReady) begin
                    expOverrun++;
                end else begin
                    expQ.push_back(word);
                    held = !doutReady;
                end
            end
        end
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 32) ? word[31-i] : 1'($urandom % 2);
            waitClk(5);
            sclk = 1'b1;
            if (checkLat && i == nbits - 1) begin
                waitClk(2);
                checkOutput("valid before latency", 32'(doutValid), 32'd0);
                checkOutput("busy in frame", 32'(busy), 32'd1);
                waitClk(1);
                checkOutput("valid at latency", 32'(doutValid), 32'd1);
                checkOutput("data at latency", dout, word);
                waitClk(1);
                checkOutput("valid single cycle", 32'(doutValid), 32'd0);
                waitClk(1);
            end else begin
                waitClk(5);
            end
            sclk = 1'b0;
            if (i == resetAt) begin
                rstN = 1'b0;
                waitClk(3);
                rstN = 1'b1;
                waitClk(1);
                checkOutput("valid after mid-frame reset", 32'(doutValid), 32'd0);
            end
        end
        waitClk(5);
        cs   = 1'b1;
        mosi = 1'b0;
    endtask

    initial begin
        int busyCycles;
        int len;
        int r;

        rstN      = 1'b0;
        cs        = 1'b1;
        sclk      = 1'b0;
        mosi      = 1'b0;
        doutReady = 1'b1;
        waitClk(4);
        checkOutput("reset dout", dout, 32'd0);
        checkOutput("reset dout_valid", 32'(doutValid), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        checkOutput("reset frame_err", 32'(frameErr), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        rstN = 1'b1;
        waitClk(6);
        checkOutput("idle busy after reset", 32'(busy), 32'd0);

        $display("[TB] single word");
        applyStimulus(32'hA5C3_0F96, 32, -1, 1'b1);
        waitClk(10);
        checkCounts("single");

        $display("[TB] back-to-back");
        applyStimulus(32'hFFFF_FFFF, 32, -1, 1'b0);
        waitClk(4);
        applyStimulus(32'h0000_0001, 32, -1, 1'b0);
        waitClk(10);
        checkCounts("back-to-back");

        $display("[TB] backpressure");
        setReady(1'b0);
        applyStimulus(32'h1234_5678, 32, -1, 1'b0);
        waitClk(4);
        applyStimulus(32'h9ABC_DEF0, 32, -1, 1'b0);
        waitClk(10);
        checkOutput("held dout", dout, 32'h1234_5678);
        checkOutput("held dout_valid", 32'(doutValid), 32'd1);
        setReady(1'b1);
        waitClk(1);
        checkOutput("valid drop after ready", 32'(doutValid), 32'd0);
        waitClk(4);
        checkCounts("backpressure");

        $display("[TB] short and long frames");
        applyStimulus($urandom, 12, -1, 1'b0);
        waitClk(6);
        applyStimulus(32'h0000_0001, 32, -1, 1'b0);
        waitClk(6);
        applyStimulus($urandom, 33, -1, 1'b0);
        waitClk(10);
        checkCounts("short/long");

        $display("[TB] idle sclk");
        busyCycles = 0;
        for (int i = 0; i < 40; i++) begin
            sclk = ~sclk;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (busy) busyCycles++;
            end
        end
        sclk = 1'b0;
        checkOutput("busy cycles with cs high", 32'(busyCycles), 32'd0);
        waitClk(6);
        checkCounts("idle sclk");

        $display("[TB] reset mid-frame");
        applyStimulus($urandom, 32, 9, 1'b0);
        waitClk(6);
        applyStimulus(32'hCAFE_F00D, 32, -1, 1'b0);
        waitClk(10);
        checkCounts("reset mid-frame");

        $display("[TB] random frames");
        for (int n = 0; n < 14; n++) begin
            setReady(1'($urandom % 2));
            r = $urandom_range(0, 9);
            if (r < 6)      len = 32;
            else if (r < 8) len = $urandom_range(1, 31);
            else            len = $urandom_range(33, 35);
            applyStimulus($urandom, len, -1, 1'b0);
            waitClk($urandom_range(2, 8));
        end
        setReady(1'b1);
        waitClk(10);
        checkCounts("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
